// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-GPR and EFLAGS write countdowns block RAW/WAW hazards.
// issue_ready is combinational from state and inputs; freeze holds all countdowns and blocks issue.
// Optional bypass assumption: define SCOREBOARD_FORWARD_EN to let final-cycle results be consumed.
package issue_scoreboard_pkg;
  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] MICRO_NOP   = 6'd0;
  localparam logic [OPCODE_W-1:0] MICRO_ADD   = 6'd1;
  localparam logic [OPCODE_W-1:0] MICRO_SUB   = 6'd2;
  localparam logic [OPCODE_W-1:0] MICRO_AND   = 6'd3;
  localparam logic [OPCODE_W-1:0] MICRO_OR    = 6'd4;
  localparam logic [OPCODE_W-1:0] MICRO_XOR   = 6'd5;
  localparam logic [OPCODE_W-1:0] MICRO_ADDI  = 6'd6;
  localparam logic [OPCODE_W-1:0] MICRO_SUBI  = 6'd7;
  localparam logic [OPCODE_W-1:0] MICRO_ANDI  = 6'd8;
  localparam logic [OPCODE_W-1:0] MICRO_ORI   = 6'd9;
  localparam logic [OPCODE_W-1:0] MICRO_XORI  = 6'd10;
  localparam logic [OPCODE_W-1:0] MICRO_LB    = 6'd11;
  localparam logic [OPCODE_W-1:0] MICRO_LW    = 6'd12;
  localparam logic [OPCODE_W-1:0] MICRO_LD    = 6'd13;
  localparam logic [OPCODE_W-1:0] MICRO_LQ    = 6'd14;
  localparam logic [OPCODE_W-1:0] MICRO_SB    = 6'd15;
  localparam logic [OPCODE_W-1:0] MICRO_SW    = 6'd16;
  localparam logic [OPCODE_W-1:0] MICRO_SD    = 6'd17;
  localparam logic [OPCODE_W-1:0] MICRO_SQ    = 6'd18;
  localparam logic [OPCODE_W-1:0] MICRO_JE    = 6'd19;
  localparam logic [OPCODE_W-1:0] MICRO_JNE   = 6'd20;
  localparam logic [OPCODE_W-1:0] MICRO_JL    = 6'd21;
  localparam logic [OPCODE_W-1:0] MICRO_JG    = 6'd22;
  localparam logic [OPCODE_W-1:0] MICRO_JR    = 6'd23;
  localparam logic [OPCODE_W-1:0] MICRO_J     = 6'd24;
  localparam logic [OPCODE_W-1:0] MICRO_MOV   = 6'd25;
  localparam logic [OPCODE_W-1:0] MICRO_MOVI  = 6'd26;
  localparam logic [OPCODE_W-1:0] MICRO_CMP   = 6'd27;
  localparam logic [OPCODE_W-1:0] MICRO_TEST  = 6'd28;
  localparam logic [OPCODE_W-1:0] MICRO_CMPI  = 6'd29;
  localparam logic [OPCODE_W-1:0] MICRO_TESTI = 6'd30;

  typedef struct packed {
    logic to_gd;
    logic from_gd;
    logic gs;
    logic gt;
    logic from_ef;
    logic to_ef;
    logic is_load;
  } usage_t;
endpackage

module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 3,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                issue_valid,
  input  logic [OPCODE_W-1:0] issue_opcode,
  input  logic [3:0]          issue_d,
  input  logic [3:0]          issue_s,
  input  logic [3:0]          issue_t,
  input  logic                freeze,
  output logic                issue_ready,
  output logic                issue_fire,
  output logic [NREG-1:0]     busy_gpr,
  output logic                busy_eflags,
  output logic [31:0]         stall_count
);

  localparam logic [CNT_W-1:0] ALU_L  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] cnt_ef_q, cnt_ef_d;
  logic [31:0]      stall_q, stall_d;

  usage_t           u;
  logic [CNT_W-1:0] lat;
  logic [3:0]       idx_d, idx_s, idx_t;
  logic             raw, waw;

  function automatic logic [3:0] clamp_idx(input logic [3:0] i);
    if (int'(i) >= NREG) return 4'(NREG - 1);
    return i;
  endfunction

  // With a bypass, a result in its last countdown cycle is already usable.
  function automatic logic rd_busy(input logic [CNT_W-1:0] c);
`ifdef SCOREBOARD_FORWARD_EN
    return c > CNT_W'(1);
`else
    return c != '0;
`endif
  endfunction

  always_comb begin
    u = '0;
    case (issue_opcode)
      MICRO_ADD, MICRO_SUB, MICRO_AND, MICRO_OR, MICRO_XOR: begin
        u.to_gd = 1'b1; u.gs = 1'b1; u.gt = 1'b1; u.from_ef = 1'b1; u.to_ef = 1'b1;
      end
      MICRO_ADDI, MICRO_SUBI, MICRO_ANDI, MICRO_ORI, MICRO_XORI: begin
        u.to_gd = 1'b1; u.gs = 1'b1; u.from_ef = 1'b1; u.to_ef = 1'b1;
      end
      MICRO_LB, MICRO_LW, MICRO_LD, MICRO_LQ: begin
        u.to_gd = 1'b1; u.gs = 1'b1; u.from_ef = 1'b1; u.to_ef = 1'b1; u.is_load = 1'b1;
      end
      MICRO_SB, MICRO_SW, MICRO_SD, MICRO_SQ: begin
        u.from_gd = 1'b1; u.gs = 1'b1; u.from_ef = 1'b1; u.to_ef = 1'b1;
      end
      MICRO_JE, MICRO_JNE, MICRO_JL, MICRO_JG, MICRO_JR: u.from_ef = 1'b1;
      MICRO_MOV: begin
        u.to_gd = 1'b1; u.gt = 1'b1;
      end
      MICRO_MOVI: u.to_gd = 1'b1;
      MICRO_CMP, MICRO_TEST: begin
        u.gs = 1'b1; u.gt = 1'b1; u.from_ef = 1'b1; u.to_ef = 1'b1;
      end
      MICRO_CMPI, MICRO_TESTI: begin
        u.gt = 1'b1; u.from_ef = 1'b1; u.to_ef = 1'b1;
      end
      default: u = '0;
    endcase
  end

  assign lat   = u.is_load ? LOAD_L : ALU_L;
  assign idx_d = clamp_idx(issue_d);
  assign idx_s = clamp_idx(issue_s);
  assign idx_t = clamp_idx(issue_t);

  assign raw = (u.gs      && rd_busy(cnt_q[idx_s])) ||
               (u.gt      && rd_busy(cnt_q[idx_t])) ||
               (u.from_gd && rd_busy(cnt_q[idx_d])) ||
               (u.from_ef && rd_busy(cnt_ef_q));

  // An older write landing on the same cycle or later would retire out of order.
  assign waw = (u.to_gd && (cnt_q[idx_d] >= lat)) ||
               (u.to_ef && (cnt_ef_q >= lat));

  assign issue_ready = rstn && !freeze && !raw && !waw;
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!freeze && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
    cnt_ef_d = cnt_ef_q;
    if (!freeze && cnt_ef_q != '0) cnt_ef_d = cnt_ef_q - CNT_W'(1);

    if (issue_fire && u.to_gd) cnt_d[idx_d] = lat;
    if (issue_fire && u.to_ef) cnt_ef_d = lat;

    stall_d = stall_q;
    if (issue_valid && !issue_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      cnt_ef_q <= '0;
      stall_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      cnt_ef_q <= cnt_ef_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    busy_gpr = '0;
    for (int i = 0; i < NREG; i++) busy_gpr[i] = (cnt_q[i] != '0);
  end

  assign busy_eflags = (cnt_ef_q != '0);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed hazard scenarios plus random traffic vs a deadline model.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic                clk = 1'b0;
  logic                rstn;
  logic                issue_valid;
  logic [OPCODE_W-1:0] issue_opcode;
  logic [3:0]          issue_d, issue_s, issue_t;
  logic                freeze;
  logic                issue_ready, issue_fire;
  logic [15:0]         busy_gpr;
  logic                busy_eflags;
  logic [31:0]         stall_count;

  issue_scoreboard dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_d(issue_d), .issue_s(issue_s), .issue_t(issue_t), .freeze(freeze),
    .issue_ready(issue_ready), .issue_fire(issue_fire), .busy_gpr(busy_gpr),
    .busy_eflags(busy_eflags), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: each pending write is an absolute deadline in "unfrozen cycles".
  int ucount;
  int done_gpr [16];
  int done_ef;
  int exp_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rem(input int deadline);
    return (deadline > ucount) ? deadline - ucount : 0;
  endfunction

  function automatic bit rdb(input int r);
`ifdef SCOREBOARD_FORWARD_EN
    return r > 1;
`else
    return r != 0;
`endif
  endfunction

  task automatic model_reset();
    ucount = 0;
    done_ef = 0;
    exp_stall = 0;
    for (int i = 0; i < 16; i++) done_gpr[i] = 0;
  endtask

  task automatic dec(input logic [5:0] op, output bit tg, output bit fg, output bit gs,
                     output bit gt, output bit fe, output bit te, output bit ld);
    bit alu_r, alu_i;
    alu_r = op inside {MICRO_ADD, MICRO_SUB, MICRO_AND, MICRO_OR, MICRO_XOR};
    alu_i = op inside {MICRO_ADDI, MICRO_SUBI, MICRO_ANDI, MICRO_ORI, MICRO_XORI};
    ld = op inside {MICRO_LB, MICRO_LW, MICRO_LD, MICRO_LQ};
    fg = op inside {MICRO_SB, MICRO_SW, MICRO_SD, MICRO_SQ};
    tg = alu_r || alu_i || ld || op inside {MICRO_MOV, MICRO_MOVI};
    gs = alu_r || alu_i || ld || fg || op inside {MICRO_CMP, MICRO_TEST};
    gt = alu_r || op inside {MICRO_MOV, MICRO_CMP, MICRO_TEST, MICRO_CMPI, MICRO_TESTI};
    te = alu_r || alu_i || ld || fg || op inside {MICRO_CMP, MICRO_TEST, MICRO_CMPI, MICRO_TESTI};
    fe = te || op inside {MICRO_JE, MICRO_JNE, MICRO_JL, MICRO_JG, MICRO_JR};
  endtask

  // One cycle: drive, check at negedge against the model, then advance the model.
  task automatic step(input bit v, input logic [5:0] op, input logic [3:0] d,
                      input logic [3:0] s, input logic [3:0] t, input bit f, output bit fired);
    bit tg, fg, gs, gt, fe, te, ld, raw, waw, er, efire;
    int lat;
    logic [15:0] eb;
    issue_valid = v; issue_opcode = op; issue_d = d; issue_s = s; issue_t = t; freeze = f;
    @(negedge clk);
    dec(op, tg, fg, gs, gt, fe, te, ld);
    lat = ld ? 3 : 1;
    raw = (gs && rdb(rem(done_gpr[s]))) || (gt && rdb(rem(done_gpr[t]))) ||
          (fg && rdb(rem(done_gpr[d]))) || (fe && rdb(rem(done_ef)));
    waw = (tg && rem(done_gpr[d]) >= lat) || (te && rem(done_ef) >= lat);
    er = !f && !raw && !waw;
    efire = v && er;
    for (int i = 0; i < 16; i++) eb[i] = (rem(done_gpr[i]) != 0);
    chk("issue_ready", 64'(issue_ready), 64'(er));
    chk("issue_fire", 64'(issue_fire), 64'(efire));
    chk("busy_gpr", 64'(busy_gpr), 64'(eb));
    chk("busy_eflags", 64'(busy_eflags), 64'(rem(done_ef) != 0));
    chk("stall_count", 64'(stall_count), 64'(exp_stall));
    fired = issue_fire;
    if (efire && tg) done_gpr[d] = ucount + 1 + lat;
    if (efire && te) done_ef = ucount + 1 + lat;
    if (v && !er) exp_stall++;
    if (!f) ucount++;
    @(posedge clk); #1;
  endtask

  // Hold one op valid until the DUT fires it; returns cycles spent waiting.
  task automatic hold(input logic [5:0] op, input logic [3:0] d, input logic [3:0] s,
                      input logic [3:0] t, output int waited);
    bit fired;
    waited = 0;
    fired = 1'b0;
    while (!fired && waited < 20) begin
      step(1'b1, op, d, s, t, 1'b0, fired);
      if (!fired) waited++;
    end
    if (!fired) begin
      errors++;
      $display("FAIL hold_timeout op=%0d waited=%0d", op, waited);
    end
  endtask

  task automatic idle(input int n);
    bit fired;
    for (int i = 0; i < n; i++) step(1'b0, MICRO_NOP, 4'd0, 4'd0, 4'd0, 1'b0, fired);
  endtask

  initial begin
    bit fired;
    int w;
    int s0;
    rstn = 1'b0; issue_valid = 1'b0; issue_opcode = MICRO_NOP;
    issue_d = 4'd0; issue_s = 4'd0; issue_t = 4'd0; freeze = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy_gpr", 64'(busy_gpr), 64'd0);
    chk("rst_busy_ef", 64'(busy_eflags), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    chk("rst_no_issue", 64'(issue_ready), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset mid-flight discards the pending load.
    step(1'b1, MICRO_LD, 4'd3, 4'd0, 4'd0, 1'b0, fired);
    chk("ld_r3_fire", 64'(fired), 64'd1);
    issue_valid = 1'b0;
    rstn = 1'b0;
    #2;
    chk("mid_rst_busy", 64'(busy_gpr), 64'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    model_reset();
    @(posedge clk); #1;
    step(1'b1, MICRO_ADD, 4'd5, 4'd3, 4'd3, 1'b0, fired);
    chk("post_rst_add_fire", 64'(fired), 64'd1);
    idle(2);

    // Load-use: three stall cycles without a bypass.
    s0 = int'(stall_count);
    step(1'b1, MICRO_LD, 4'd1, 4'd0, 4'd0, 1'b0, fired);
    hold(MICRO_ADD, 4'd6, 4'd1, 4'd7, w);
`ifndef SCOREBOARD_FORWARD_EN
    chk("load_use_wait", 64'(w), 64'd3);
    chk("load_use_stalls", 64'(int'(stall_count) - s0), 64'd3);
`endif
    idle(2);

    // EFLAGS chain: CMPI then JE.
    step(1'b1, MICRO_CMPI, 4'd0, 4'd0, 4'd2, 1'b0, fired);
    hold(MICRO_JE, 4'd0, 4'd0, 4'd0, w);
`ifndef SCOREBOARD_FORWARD_EN
    chk("eflags_chain_wait", 64'(w), 64'd1);
`else
    chk("eflags_chain_wait", 64'(w), 64'd0);
`endif
    idle(2);

    // WAW: a later short write must not overtake a pending load.
    step(1'b1, MICRO_LD, 4'd2, 4'd0, 4'd0, 1'b0, fired);
    hold(MICRO_MOVI, 4'd2, 4'd0, 4'd0, w);
    chk("waw_wait", 64'(w), 64'd3);
    idle(2);

    // Freeze holds the countdown.
    step(1'b1, MICRO_ADDI, 4'd4, 4'd0, 4'd0, 1'b0, fired);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, MICRO_NOP, 4'd0, 4'd0, 4'd0, 1'b1, fired);
      chk("freeze_busy4", 64'(busy_gpr[4]), 64'd1);
    end
    hold(MICRO_ADD, 4'd8, 4'd4, 4'd0, w);
`ifndef SCOREBOARD_FORWARD_EN
    chk("freeze_wait", 64'(w), 64'd1);
`endif
    idle(3);

    // Back-to-back independent ops.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, MICRO_MOVI, 4'(9 + i), 4'd0, 4'd0, 1'b0, fired);
      chk("b2b_fire", 64'(fired), 64'd1);
    end
    idle(3);

    // Random traffic over a few registers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 6'($urandom_range(0, 40)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, fired);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
